// File: rtl/ikaopm_so_pkg.sv
// Shared constants and types for the serial sound-output (SO) decoder.
// Bit positions refer to the index k of a bit within a 16-bit SO word.
package ikaopm_so_pkg;

  localparam int WORD_LEN     = 16;
  localparam int MANT_LSB_IDX = 0;
  localparam int SIGN_IDX     = 9;
  localparam int EXP_LSB_IDX  = 10;
  localparam int DECODE_IDX   = 12;

  localparam int MANT_W = SIGN_IDX - MANT_LSB_IDX;
  localparam int EXP_W  = DECODE_IDX - EXP_LSB_IDX + 1;
  localparam int PCM_W  = 16;

  typedef enum logic {
    HUNT = 1'b0,
    RUN  = 1'b1
  } so_state_t;

  localparam logic CH_R = 1'b0;
  localparam logic CH_L = 1'b1;

endpackage

// File: rtl/ikaopm_so_decoder_if.sv
// SO decoder bus: serial input side plus decoded PCM and status outputs.
// Clock and reset are kept as plain ports on the decoder itself.
interface ikaopm_so_decoder_if;
  import ikaopm_so_pkg::*;

  logic             i_phi1_NCEN_n;
  logic             i_SO;
  logic             i_WORD_SYNC;
  logic             i_WORD_CH;
  logic [PCM_W-1:0] o_R_PCM;
  logic [PCM_W-1:0] o_L_PCM;
  logic             o_PAIR_VALID;
  logic             o_LOCKED;
  logic             o_SYNC_ERR;
  logic             o_EXP_ERR;

  modport master (
    output i_phi1_NCEN_n, i_SO, i_WORD_SYNC, i_WORD_CH,
    input  o_R_PCM, o_L_PCM, o_PAIR_VALID, o_LOCKED, o_SYNC_ERR, o_EXP_ERR
  );

  modport slave (
    input  i_phi1_NCEN_n, i_SO, i_WORD_SYNC, i_WORD_CH,
    output o_R_PCM, o_L_PCM, o_PAIR_VALID, o_LOCKED, o_SYNC_ERR, o_EXP_ERR
  );

endinterface

// File: rtl/ikaopm_so_fpdecode.sv
// Combinational floating-point to PCM conversion of one SO word.
// Offset-binary mantissa {~s, m} is sign-extended and shifted by e-1.
module ikaopm_so_fpdecode
  import ikaopm_so_pkg::*;
(
  input  logic              s_i,
  input  logic [MANT_W-1:0] m_i,
  input  logic [EXP_W-1:0]  e_i,
  output logic [PCM_W-1:0]  pcm_o,
  output logic              exp_err_o
);

  logic [PCM_W-1:0] v_ext;

  always_comb begin
    v_ext     = {{(PCM_W - MANT_W){~s_i}}, m_i};
    pcm_o     = '0;
    exp_err_o = 1'b0;
    // A zero exponent is not a legal encoding; it decodes as silence.
    if (e_i == '0) begin
      exp_err_o = 1'b1;
    end else begin
      pcm_o = v_ext << (e_i - 1'b1);
    end
  end

endmodule

// File: rtl/ikaopm_so_decoder.sv
// YM3012-style front end: deserialises SO words, tracks word sync and
// loads decoded PCM into the R or L output register at bit 12.
module ikaopm_so_decoder
  import ikaopm_so_pkg::*;
#(
  parameter int MISS_LIMIT = 2
) (
  input  logic                i_EMUCLK,
  input  logic                i_MRST,
  ikaopm_so_decoder_if.slave  so_if
);

  localparam int                CNT_W        = $clog2(WORD_LEN);
  localparam int                MISS_W       = $clog2(MISS_LIMIT + 1);
  localparam logic [CNT_W-1:0]  DECODE_CNT   = CNT_W'(DECODE_IDX);
  localparam logic [MISS_W-1:0] MISS_LIMIT_W = MISS_W'(MISS_LIMIT);

  so_state_t             state_q, state_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic [DECODE_IDX-1:0] word_q, word_d;
  logic                  ch_q, ch_d;
  logic [MISS_W-1:0]     miss_q, miss_d;
  logic [PCM_W-1:0]      r_pcm_q, r_pcm_d;
  logic [PCM_W-1:0]      l_pcm_q, l_pcm_d;
  logic                  pair_valid_q, pair_valid_d;
  logic                  sync_err_q, sync_err_d;
  logic                  exp_err_q, exp_err_d;

  logic                  en;
  logic [MISS_W-1:0]     miss_inc;
  logic                  start;
  logic                  start_ch;
  logic [PCM_W-1:0]      dec_pcm;
  logic                  dec_exp_err;

  assign en       = ~so_if.i_phi1_NCEN_n;
  assign miss_inc = miss_q + 1'b1;

  // Exponent MSB is the bit on the wire during the decode cycle itself.
  ikaopm_so_fpdecode u_fpdecode (
    .s_i       (word_q[SIGN_IDX]),
    .m_i       (word_q[SIGN_IDX-1:MANT_LSB_IDX]),
    .e_i       ({so_if.i_SO, word_q[DECODE_IDX-1:EXP_LSB_IDX]}),
    .pcm_o     (dec_pcm),
    .exp_err_o (dec_exp_err)
  );

  // NOTE: every next-state value takes its held value first, so no path
  // through this block leaves a signal unassigned and no latch is inferred.
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    word_d       = word_q;
    ch_d         = ch_q;
    miss_d       = miss_q;
    r_pcm_d      = r_pcm_q;
    l_pcm_d      = l_pcm_q;
    pair_valid_d = 1'b0;
    sync_err_d   = sync_err_q;
    exp_err_d    = exp_err_q;
    start        = 1'b0;
    start_ch     = ch_q;

    if (en) begin
      if (state_q == HUNT) begin
        if (so_if.i_WORD_SYNC) begin
          state_d  = RUN;
          start    = 1'b1;
          start_ch = so_if.i_WORD_CH;
        end
      end else if (so_if.i_WORD_SYNC) begin
        // A sync anywhere but bit 0 abandons the partial word, even at bit 12.
        if (cnt_q != '0) sync_err_d = 1'b1;
        miss_d   = '0;
        start    = 1'b1;
        start_ch = so_if.i_WORD_CH;
      end else if (cnt_q == '0) begin
        if (miss_inc >= MISS_LIMIT_W) begin
          state_d = HUNT;
          miss_d  = '0;
        end else begin
          miss_d   = miss_inc;
          start    = 1'b1;
          start_ch = ~ch_q;
        end
      end else begin
        for (int k = 1; k < DECODE_IDX; k++) begin
          if (cnt_q == CNT_W'(k)) word_d[k] = so_if.i_SO;
        end
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == DECODE_CNT) begin
          if (ch_q == CH_L) begin
            l_pcm_d      = dec_pcm;
            pair_valid_d = 1'b1;
          end else begin
            r_pcm_d = dec_pcm;
          end
          if (dec_exp_err) exp_err_d = 1'b1;
        end
      end
    end

    if (start) begin
      cnt_d                = CNT_W'(1);
      ch_d                 = start_ch;
      word_d[MANT_LSB_IDX] = so_if.i_SO;
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge value of every other flop, independent of statement order.
  always_ff @(posedge i_EMUCLK or posedge i_MRST) begin
    if (i_MRST) begin
      state_q      <= HUNT;
      cnt_q        <= '0;
      word_q       <= '0;
      ch_q         <= CH_R;
      miss_q       <= '0;
      r_pcm_q      <= '0;
      l_pcm_q      <= '0;
      pair_valid_q <= 1'b0;
      sync_err_q   <= 1'b0;
      exp_err_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      word_q       <= word_d;
      ch_q         <= ch_d;
      miss_q       <= miss_d;
      r_pcm_q      <= r_pcm_d;
      l_pcm_q      <= l_pcm_d;
      pair_valid_q <= pair_valid_d;
      sync_err_q   <= sync_err_d;
      exp_err_q    <= exp_err_d;
    end
  end

  assign so_if.o_R_PCM      = r_pcm_q;
  assign so_if.o_L_PCM      = l_pcm_q;
  assign so_if.o_PAIR_VALID = pair_valid_q;
  assign so_if.o_LOCKED     = (state_q == RUN);
  assign so_if.o_SYNC_ERR   = sync_err_q;
  assign so_if.o_EXP_ERR    = exp_err_q;

endmodule

// File: tb/tb_ikaopm_so_decoder.sv
// Scoreboarded bench for ikaopm_so_decoder: L-channel decodes are predicted
// from the arithmetic value of each word and compared at every pair strobe.
module tb_ikaopm_so_decoder;
  import ikaopm_so_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  ikaopm_so_decoder_if bus ();

  ikaopm_so_decoder #(.MISS_LIMIT(2)) dut (
    .i_EMUCLK (clk),
    .i_MRST   (rst),
    .so_if    (bus)
  );

  typedef struct {
    logic [15:0] r;
    logic [15:0] l;
  } pair_t;

  pair_t       exp_q[$];
  pair_t       mon_p;
  int          n_tests   = 0;
  int          n_fail    = 0;
  int          strobes   = 0;
  int          n_push    = 0;
  int          sb_before = 0;
  bit          gate_mode = 1'b0;
  logic [15:0] r_exp     = '0;
  logic [15:0] l_exp     = '0;
  logic        pv_prev   = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Signed value of the word: offset-binary mantissa times 2^(e-1).
  function automatic logic [15:0] ref_pcm(input bit s, input bit [8:0] m, input bit [2:0] e);
    int v;
    if (e == 3'd0) return 16'h0000;
    v = (s ? int'(m) : int'(m) - 512) * (1 << (e - 1));
    return v[15:0];
  endfunction

  task automatic model_word(input bit ch, input bit s, input bit [8:0] m, input bit [2:0] e);
    if (ch == CH_L) begin
      l_exp = ref_pcm(s, m, e);
      exp_q.push_back('{r_exp, l_exp});
      n_push++;
    end else begin
      r_exp = ref_pcm(s, m, e);
    end
  endtask

  always @(negedge clk) begin
    if (pv_prev) check("pv_one_cycle", 32'(bus.o_PAIR_VALID), 32'd0);
    if (bus.o_PAIR_VALID) begin
      strobes++;
      if (exp_q.size() == 0) begin
        check("sb_pending", 32'(exp_q.size()), 32'd1);
      end else begin
        mon_p = exp_q.pop_front();
        check("sb_l_pcm", 32'(bus.o_L_PCM), 32'(mon_p.l));
        check("sb_r_pcm", 32'(bus.o_R_PCM), 32'(mon_p.r));
      end
    end
    pv_prev = bus.o_PAIR_VALID;
  end

  task automatic drive(input bit ncen, input bit so, input bit sync, input bit ch);
    @(negedge clk);
    bus.i_phi1_NCEN_n = ncen;
    bus.i_SO          = so;
    bus.i_WORD_SYNC   = sync;
    bus.i_WORD_CH     = ch;
    @(posedge clk);
  endtask

  // Disabled cycles carry random junk that must be ignored.
  task automatic send_bit(input bit b, input bit sync, input bit ch);
    if (gate_mode) repeat (3) drive(1'b1, 1'($urandom), 1'($urandom), 1'($urandom));
    drive(1'b0, b, sync, ch);
  endtask

  task automatic send_word(input bit sync, input bit ch, input bit s, input bit [8:0] m,
                           input bit [2:0] e, input int n_bits = 16);
    logic [15:0] w;
    w = {3'($urandom), e, s, m};
    for (int k = 0; k < n_bits; k++) send_bit(w[k], sync && (k == 0), ch);
  endtask

  task automatic rand_word(input bit sync, input bit ch);
    bit       s;
    bit [8:0] m;
    bit [2:0] e;
    s = 1'($urandom);
    m = 9'($urandom);
    e = 3'($urandom_range(1, 7));
    model_word(ch, s, m, e);
    send_word(sync, ch, s, m, e);
  endtask

  task automatic fixed_word(input bit ch, input bit s, input bit [8:0] m, input bit [2:0] e);
    model_word(ch, s, m, e);
    send_word(1'b1, ch, s, m, e);
    #1;
  endtask

  initial begin
    bus.i_phi1_NCEN_n = 1'b1;
    bus.i_SO          = 1'b0;
    bus.i_WORD_SYNC   = 1'b0;
    bus.i_WORD_CH     = 1'b0;

    repeat (2) @(posedge clk);
    #1;
    check("rst_r_pcm", 32'(bus.o_R_PCM), 32'h0);
    check("rst_l_pcm", 32'(bus.o_L_PCM), 32'h0);
    check("rst_pv", 32'(bus.o_PAIR_VALID), 32'h0);
    check("rst_locked", 32'(bus.o_LOCKED), 32'h0);
    check("rst_sync_err", 32'(bus.o_SYNC_ERR), 32'h0);
    check("rst_exp_err", 32'(bus.o_EXP_ERR), 32'h0);
    @(negedge clk);
    rst = 1'b0;

    sb_before = strobes;
    fixed_word(CH_R, 1'b1, 9'h000, 3'd1);
    check("zero_r_pcm", 32'(bus.o_R_PCM), 32'h0000);
    check("zero_locked", 32'(bus.o_LOCKED), 32'd1);
    check("zero_no_strobe", 32'(strobes), 32'(sb_before));

    fixed_word(CH_L, 1'b1, 9'h1FF, 3'd7);
    check("pos_full_l", 32'(bus.o_L_PCM), 32'h7FC0);
    fixed_word(CH_R, 1'b0, 9'h000, 3'd7);
    check("neg_full_r", 32'(bus.o_R_PCM), 32'h8000);
    fixed_word(CH_L, 1'b0, 9'h1FF, 3'd1);
    check("minus_one_l", 32'(bus.o_L_PCM), 32'hFFFF);
    fixed_word(CH_R, 1'b1, 9'h005, 3'd3);
    check("mid_r", 32'(bus.o_R_PCM), 32'h0014);

    gate_mode = 1'b1;
    fixed_word(CH_R, 1'b1, 9'h005, 3'd3);
    check("mid_r_gated", 32'(bus.o_R_PCM), 32'h0014);
    fixed_word(CH_L, 1'b1, 9'h005, 3'd3);
    check("mid_l_gated", 32'(bus.o_L_PCM), 32'h0014);

    for (int i = 0; i < 40; i++) begin
      gate_mode = 1'($urandom);
      rand_word(1'b1, 1'($urandom));
    end
    gate_mode = 1'b0;
    #1;
    check("rand_r_pcm", 32'(bus.o_R_PCM), 32'(r_exp));
    check("rand_sync_err", 32'(bus.o_SYNC_ERR), 32'd0);
    check("rand_exp_err", 32'(bus.o_EXP_ERR), 32'd0);

    // Partial R word cut by a sync at k=7 must not reach the R register.
    send_word(1'b1, CH_R, 1'b1, 9'h0AA, 3'd4, 7);
    rand_word(1'b1, CH_L);
    #1;
    check("k7_sync_err", 32'(bus.o_SYNC_ERR), 32'd1);
    check("k7_r_kept", 32'(bus.o_R_PCM), 32'(r_exp));

    // Sync landing exactly on bit 12 suppresses that word's decode.
    send_word(1'b1, CH_R, 1'b0, 9'h123, 3'd5, 12);
    rand_word(1'b1, CH_L);
    rand_word(1'b1, CH_R);
    rand_word(1'b1, CH_L);

    rand_word(1'b1, CH_R);
    rand_word(1'b0, CH_L);
    #1;
    check("miss1_locked", 32'(bus.o_LOCKED), 32'd1);
    send_bit(1'($urandom), 1'b0, 1'b0);
    #1;
    check("miss2_unlocked", 32'(bus.o_LOCKED), 32'd0);
    for (int k = 1; k < 16; k++) send_bit(1'($urandom), 1'b0, 1'b0);
    #1;
    check("hunt_stays", 32'(bus.o_LOCKED), 32'd0);
    rand_word(1'b1, CH_R);
    rand_word(1'b1, CH_L);
    #1;
    check("relocked", 32'(bus.o_LOCKED), 32'd1);

    check("exp0_before", 32'(bus.o_EXP_ERR), 32'd0);
    fixed_word(CH_L, 1'b1, 9'h1AB, 3'd0);
    check("exp0_l_pcm", 32'(bus.o_L_PCM), 32'h0000);
    check("exp0_err", 32'(bus.o_EXP_ERR), 32'd1);

    fixed_word(CH_R, 1'b1, 9'h0F0, 3'd4);
    fixed_word(CH_L, 1'b0, 9'h0F0, 3'd2);
    check("pre_rst_l", 32'(bus.o_L_PCM), 32'hFDE0);
    send_word(1'b1, CH_R, 1'b1, 9'h055, 3'd6, 5);
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    check("mrst_r_pcm", 32'(bus.o_R_PCM), 32'h0);
    check("mrst_l_pcm", 32'(bus.o_L_PCM), 32'h0);
    check("mrst_pv", 32'(bus.o_PAIR_VALID), 32'h0);
    check("mrst_locked", 32'(bus.o_LOCKED), 32'h0);
    check("mrst_sync_err", 32'(bus.o_SYNC_ERR), 32'h0);
    check("mrst_exp_err", 32'(bus.o_EXP_ERR), 32'h0);
    r_exp = '0;
    l_exp = '0;
    @(negedge clk);
    bus.i_phi1_NCEN_n = 1'b1;
    bus.i_WORD_SYNC   = 1'b0;
    rst = 1'b0;

    rand_word(1'b1, CH_R);
    rand_word(1'b1, CH_L);
    #1;
    check("post_rst_r", 32'(bus.o_R_PCM), 32'(r_exp));

    repeat (4) drive(1'b1, 1'b0, 1'b0, 1'b0);
    check("sb_drained", 32'(exp_q.size()), 32'd0);
    check("strobe_count", 32'(strobes), 32'(n_push));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
